mem_resp_stall: RTL
===================

# mem_resp_stall

Word-addressed SRAM responder for the 32-bit req/gnt memory interface driven by the core's instruction and data ports. Unlike the always-granting SRAM wrapper, it exercises the initiator side of the protocol. It withholds `gnt_o` pseudo-randomly and returns read data after a fixed, parameterised latency, qualified by `rvalid_o`. It sits in the SoC in place of either memory and is used to stress-test the core's handshake logic.

## Interface
- `Depth`, 1024: memory size in 32-bit words; power of two.
- `BaseAddr`, 32'h8000_0000: byte address of word 0.
- `Latency`, 2: cycles from accepted request to `rvalid_o`; legal range 1..4.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  initiator request; must be held with stable payload until granted.
- `gnt_o`  out  1  grant; a transfer is accepted on a cycle with `req_i & gnt_o`.
- `addr_i`  in  32  byte address; bits [1:0] ignored.
- `we_i`  in  1  1 = write, 0 = read.
- `wdata_i`  in  32  write data.
- `strb_i`  in  4  byte strobes; bit k enables byte k.
- `rvalid_o`  out  1  response valid, one cycle per accepted transfer.
- `rdata_o`  out  32  read data; 0 for write responses.
- `err_o`  out  1  response is for an out-of-range address; valid with `rvalid_o`.
- `stall_en_i`  in  1  enable pseudo-random grant stalls.
- `stall_thresh_i`  in  4  stall when LFSR[3:0] < threshold; 0 = never stall.

## Operation
- Word index: `idx = (addr_i - BaseAddr) >> 2`, 32-bit modular arithmetic.
  - In range iff `idx < Depth`.
  - Out of range: a write is dropped; a read returns 32'hDEAD_BEEF. Both responses carry `err_o = 1`.
- Grant: `gnt_o = ~(stall_en_i & (lfsr[3:0] < stall_thresh_i))`.
  - Purely combinational from registered LFSR state and the two stall inputs.
  - Independent of `req_i`; `gnt_o` may be high with no request.
- LFSR: 16-bit Galois, polynomial mask 16'hB400.
  - Advances every cycle, whether or not a request is present.
  - Reset value 16'hACE1; it never reaches 0.
- Write accept: every byte lane with its strobe bit set is written at the accepting clock edge. A write with strobe 4'b0000 still produces a response.
- Read accept: the word is read at the accepting edge. A write to the same word in the previous accepted cycle is visible (read-after-write holds for back-to-back requests).
- Response pipeline: `Latency` stages, each holding {valid, err, data}.
  - Stage 0 is loaded at accept; the last stage drives the outputs.
  - Responses return in request order.
  - Throughput is one transfer per cycle when there are no stalls.
- No backpressure on responses; the initiator must always sink `rvalid_o`.

## Timing
- Reset values: `rvalid_o = 0`, `rdata_o = 0`, `err_o = 0`, all pipeline stages invalid, LFSR = 16'hACE1.
- `gnt_o` resets to 1 if `stall_en_i = 0`; otherwise it follows the reset LFSR value.
- Memory contents are not reset.
- Accept at edge N → `rvalid_o` high during cycle N+`Latency`.
  - Example, `Latency = 1`: response in the cycle right after the accept.
- Reset asserted mid-operation: all in-flight responses are discarded; no `rvalid_o` follows reset deassertion until a new accept. Memory writes already committed stay committed.
- `req_i` high while `gnt_o` low: no state change other than the LFSR. The initiator must hold its payload.
- `stall_thresh_i` changes take effect in the same cycle (combinational).

## Structure
- Package `mem_resp_pkg`:
  - types `data_t`, `addr_t`, `strb_t`;
  - constants `LfsrSeed = 16'hACE1`, `LfsrMask = 16'hB400`, `ErrData = 32'hDEAD_BEEF`;
  - a response-stage struct type.
- Sub-module `mem_resp_lfsr`: 16-bit Galois LFSR with async active-high reset. `mem_resp_stall` instantiates it.
- Memory array and response pipeline live in `mem_resp_stall`.

## Test plan
- `stall_en_i = 0`, `Latency = 2`:
  - write 32'h1234_5678 to 0x8000_0010 (strobe 4'hF), then read it back-to-back → `rdata_o = 32'h1234_5678` exactly 2 cycles after the read accept;
  - `gnt_o` stays 1 throughout.
- Partial write: word holds 32'hFFFF_FFFF; write 32'h0000_00AA with strobe 4'b0001 → a read returns 32'hFFFF_FFAA.
- Out-of-range read at 0x7FFF_FFFC and at `BaseAddr + 4*Depth` → 32'hDEAD_BEEF with `err_o = 1`; the preceding in-range word is unchanged.
- `stall_en_i = 1`, `stall_thresh_i = 8`, 200 random transfers:
  - `gnt_o` low on some cycles;
  - responses equal accepts, in order, each exactly `Latency` cycles after its accept;
  - results match a scoreboard model.
- `stall_thresh_i = 0` with `stall_en_i = 1` → `gnt_o` constant 1. `stall_thresh_i = 15` → the `gnt_o` pattern matches the reference LFSR sequence from 16'hACE1.
- Issue 2 reads, assert `rst_i` for 1 cycle before their responses → no `rvalid_o` after reset. Memory retains data written before reset.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the stalling SRAM responder.
//   data_t / addr_t / strb_t : bus payload types of the 32-bit req/gnt interface
//   LfsrSeed / LfsrMask      : reset value and Galois feedback mask of the stall LFSR
//   ErrData                  : read data returned for out-of-range addresses
//   resp_stage_t             : one slot of the response pipeline {valid, err, data}
//   lfsr_next()              : one step of the right-shifting Galois LFSR
package mem_resp_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;
    typedef logic [3:0]  strb_t;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrMask = 16'hB400;
    localparam data_t       ErrData  = 32'hDEAD_BEEF;

    typedef struct packed {
        logic  valid;
        logic  err;
        data_t data;
    } resp_stage_t;

    // Shift right; when the bit falling out is 1, fold the feedback mask in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LfsrMask : 16'h0000);
    endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// mem_resp_lfsr: free-running 16-bit Galois LFSR used to decide grant stalls.
//   clk_i  : clock, state advances on every rising edge
//   rst_i  : asynchronous active-high reset, loads LfsrSeed
//   lfsr_o : current registered LFSR state
// A non-zero seed keeps the register out of the all-zero lock-up state.
module mem_resp_lfsr
    import mem_resp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mem_resp_stall.sv
// mem_resp_stall: word-addressed SRAM responder that withholds grants
// pseudo-randomly and answers after a fixed latency.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   req_i / gnt_o          : request / grant; a transfer is accepted on req_i & gnt_o
//   addr_i, we_i           : byte address (bits [1:0] ignored), write enable
//   wdata_i, strb_i        : write data and byte strobes
//   rvalid_o, rdata_o      : one response per accepted transfer, Latency cycles later
//   err_o                  : response belongs to an out-of-range address
//   stall_en_i             : enable grant stalls
//   stall_thresh_i         : stall while LFSR[3:0] < threshold
// Handshake: the initiator holds req_i and its payload stable until it sees
// gnt_o high on a rising edge; responses have no backpressure and must be sunk.
module mem_resp_stall
    import mem_resp_pkg::*;
#(
    parameter int    Depth    = 1024,
    parameter addr_t BaseAddr = 32'h8000_0000,
    parameter int    Latency  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  addr_t       addr_i,
    input  logic        we_i,
    input  data_t       wdata_i,
    input  strb_t       strb_i,
    output logic        rvalid_o,
    output data_t       rdata_o,
    output logic        err_o,
    input  logic        stall_en_i,
    input  logic [3:0]  stall_thresh_i
);

    localparam int AW = $clog2(Depth);

    logic [15:0]  lfsr_w;
    logic         accept;
    addr_t        offset;
    logic         in_range;
    logic [AW-1:0] widx;
    data_t        mem [Depth];
    resp_stage_t  stage_d;
    resp_stage_t  pipe_q [Latency];

    mem_resp_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (lfsr_w)
    );

    // Grant never looks at req_i so the initiator cannot influence stalls.
    assign gnt_o  = ~(stall_en_i & (lfsr_w[3:0] < stall_thresh_i));
    assign accept = req_i & gnt_o;

    // Modular subtraction: addresses below BaseAddr wrap to huge offsets and
    // fall out of range together with addresses past the end of the array.
    assign offset   = addr_i - BaseAddr;
    assign in_range = ~|offset[31:AW+2];
    assign widx     = offset[AW+1:2];

    // Memory is deliberately not reset; committed writes survive rst_i.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (strb_i[k]) begin
                    mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // The read samples the array before this edge's write lands, so a write
    // accepted on the previous edge is already visible here.
    always_comb begin
        stage_d = '0;
        if (accept) begin
            stage_d.valid = 1'b1;
            stage_d.err   = ~in_range;
            if (we_i) begin
                stage_d.data = '0;
            end else if (in_range) begin
                stage_d.data = mem[widx];
            end else begin
                stage_d.data = ErrData;
            end
        end
    end

    // Idle slots carry all-zero payload, so rdata_o/err_o read 0 between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_d;
            for (int i = 1; i < Latency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rvalid_o = pipe_q[Latency-1].valid;
    assign err_o    = pipe_q[Latency-1].err;
    assign rdata_o  = pipe_q[Latency-1].data;

    logic unused_bits;
    assign unused_bits = ^{offset[1:0], lfsr_w[15:4]};

endmodule
